// File: rtl/painterengine_gpu_writer_scheduler.sv
// Round-robin scheduler that runs one DMA writer job at a time for four channels.
// It owns the writer's reset and channel routing, and it reports each job's outcome back to the channel that requested it.
module painterengine_gpu_writer_scheduler #(
    parameter logic [31:0] PARAM_TIMEOUT        = 32'd65536,
    parameter int unsigned PARAM_RESTART_CYCLES = 4
) (
    input  logic       i_wire_clock,
    input  logic       i_wire_reset,
    input  logic [3:0] i_wire_request,
    output logic [3:0] o_wire_grant,
    output logic [3:0] o_wire_channel_done,
    output logic [3:0] o_wire_channel_error,
    output logic [2:0] o_wire_last_error_type,
    output logic       o_wire_busy,
    output logic [3:0] o_wire_writer_router,
    output logic       o_wire_writer_resetn,
    input  logic       i_wire_writer_done,
    input  logic       i_wire_writer_error,
    input  logic [2:0] i_wire_writer_error_type
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_START,
        ST_RUN,
        ST_REPORT,
        ST_RECOVER
    } state_t;

    localparam logic [31:0] TIMEOUT_LAST = PARAM_TIMEOUT - 32'd1;
    localparam logic [7:0]  RESTART_LAST = 8'(PARAM_RESTART_CYCLES - 1);

    state_t      state;
    state_t      next_state;
    logic [3:0]  grant;
    logic [1:0]  rr_last;
    logic [31:0] timer;
    logic [7:0]  restart_cnt;
    logic        writer_resetn;
    logic [3:0]  done_pulse;
    logic [3:0]  error_pulse;
    logic [2:0]  last_error_type;

    logic        arb_found;
    logic [1:0]  arb_idx;
    logic [1:0]  cand;
    logic        status_valid;
    logic        run_error;
    logic        run_timeout;
    logic        run_done;
    logic        run_exit;

    // Round-robin search that starts one past the last granted channel and wraps.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = rr_last;
        cand      = rr_last;
        for (int k = 0; k < 4; k++) begin
            cand = rr_last + 2'(k + 1);
            if (!arb_found && i_wire_request[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    // The writer leaves reset on the first RUN cycle, so its status is only trusted from the second cycle on.
    always_comb begin
        status_valid = (timer != 32'd0);
        run_error    = status_valid && i_wire_writer_error;
        run_timeout  = (timer == TIMEOUT_LAST);
        run_done     = status_valid && i_wire_writer_done;
        run_exit     = run_error || run_timeout || run_done;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE:    if (|i_wire_request) next_state = ST_ARB;
            ST_ARB:     next_state = arb_found ? ST_START : ST_IDLE;
            ST_START:   next_state = ST_RUN;
            ST_RUN:     if (run_exit) next_state = ST_REPORT;
            ST_REPORT:  next_state = ST_RECOVER;
            ST_RECOVER: if (restart_cnt == RESTART_LAST) next_state = ST_IDLE;
            default:    next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_wire_clock) begin
        if (i_wire_reset) begin
            state           <= ST_IDLE;
            grant           <= 4'b0000;
            rr_last         <= 2'd3;
            timer           <= 32'd0;
            restart_cnt     <= 8'd0;
            writer_resetn   <= 1'b0;
            done_pulse      <= 4'b0000;
            error_pulse     <= 4'b0000;
            last_error_type <= 3'b000;
        end else begin
            state       <= next_state;
            done_pulse  <= 4'b0000;
            error_pulse <= 4'b0000;
            unique case (state)
                ST_IDLE: begin
                    writer_resetn <= 1'b0;
                end
                ST_ARB: begin
                    if (arb_found) begin
                        grant   <= 4'b0001 << arb_idx;
                        rr_last <= arb_idx;
                    end
                end
                ST_START: begin
                    writer_resetn <= 1'b1;
                    timer         <= 32'd0;
                end
                ST_RUN: begin
                    timer <= timer + 32'd1;
                    // Outcome priority: writer error, then timeout, then normal completion.
                    if (run_error) begin
                        error_pulse     <= grant;
                        last_error_type <= i_wire_writer_error_type;
                    end else if (run_timeout) begin
                        error_pulse     <= grant;
                        last_error_type <= 3'b111;
                    end else if (run_done) begin
                        done_pulse <= grant;
                    end
                end
                ST_REPORT: begin
                    grant         <= 4'b0000;
                    writer_resetn <= 1'b0;
                    restart_cnt   <= 8'd0;
                end
                ST_RECOVER: begin
                    restart_cnt <= restart_cnt + 8'd1;
                end
                default: begin
                    writer_resetn <= 1'b0;
                end
            endcase
        end
    end

    assign o_wire_grant           = grant;
    assign o_wire_writer_router   = grant;
    assign o_wire_writer_resetn   = writer_resetn;
    assign o_wire_channel_done    = done_pulse;
    assign o_wire_channel_error   = error_pulse;
    assign o_wire_last_error_type = last_error_type;
    assign o_wire_busy            = (state != ST_IDLE);

endmodule
